// File: rtl/stream_downsizer.sv
// Splits each IN_WIDTH word into RATIO narrower beats over valid/ready.
// A word can be accepted in the same cycle that the previous word's last beat leaves.
//
// state | meaning
// IDLE  | no word held, ready for a new word
// BUSY  | word held, cnt_q selects the beat currently presented
module stream_downsizer #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_data,
   output logic                 out_last
);

   localparam int RATIO = IN_WIDTH / OUT_WIDTH;
   localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

   if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_ratio
      $fatal(1, "stream_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH");
   end

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [IN_WIDTH-1:0] hold_q;

   assign out_valid = (state_q == BUSY);
   assign out_last  = (state_q == BUSY) && (cnt_q == CNT_W'(RATIO - 1));
   assign in_ready  = (state_q == IDLE) || (out_ready && out_last);

   always_comb begin
      out_data = '0;
      if (state_q == BUSY) begin
         for (int i = 0; i < RATIO; i++) begin
            if (cnt_q == CNT_W'(i))
               out_data = hold_q[(MSB_FIRST ? (RATIO - 1 - i) : i) * OUT_WIDTH +: OUT_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  hold_q  <= in_data;
                  cnt_q   <= '0;
                  state_q <= BUSY;
               end
            end
            BUSY: begin
               if (out_ready) begin
                  if (!out_last) begin
                     cnt_q <= cnt_q + CNT_W'(1);
                  end else if (in_valid) begin
                     // back-to-back: reload without an idle cycle
                     hold_q <= in_data;
                     cnt_q  <= '0;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_downsizer.sv
// Directed bench for stream_downsizer: 32->8 LSB-first instance and 32->16 MSB-first instance.
module tb_stream_downsizer;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        in_valid, in_ready, out_valid, out_ready, out_last;
   logic [31:0] in_data;
   logic [7:0]  out_data;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
   logic [31:0] b_in_data;
   logic [15:0] b_out_data;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   stream_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(16), .MSB_FIRST(1'b1)) u_dut_msb (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_data   (b_in_data),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_last  (b_out_last)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic beat(input string tag, input logic [7:0] d, input logic last, input logic rdy);
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"},  32'(out_data),  32'(d));
      chk({tag, "_last"},  32'(out_last),  32'(last));
      chk({tag, "_inrdy"}, 32'(in_ready),  32'(rdy));
   endtask

   logic [7:0] exp_single [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
   logic [7:0] exp_b2b    [8] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
   logic [7:0] exp_bp     [4] = '{8'h0F, 8'h0F, 8'hA5, 8'hA5};
   logic [7:0] exp_one    [4] = '{8'h01, 8'h00, 8'h00, 8'h00};

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last",  32'(out_last),  32'd0);
      chk("rst_inrdy", 32'(in_ready),  32'd1);
      chk("rst_data",  32'(out_data),  32'd0);

      // single word, LSB first
      @(negedge clk); in_valid = 1'b1; in_data = 32'hDEADBEEF; out_ready = 1'b1; #1;
      chk("single_idle_inrdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); in_valid = 1'b0; in_data = '0; #1;
         beat($sformatf("single%0d", i), exp_single[i], i == 3, i == 3);
      end
      @(negedge clk); #1;
      chk("single_done_valid", 32'(out_valid), 32'd0);
      chk("single_done_inrdy", 32'(in_ready),  32'd1);

      // back-to-back words
      @(negedge clk); in_valid = 1'b1; in_data = 32'h11223344; #1;
      chk("b2b_idle_inrdy", 32'(in_ready), 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); in_valid = (i < 4); in_data = 32'hCAFEF00D; #1;
         beat($sformatf("b2b%0d", i), exp_b2b[i], (i == 3) || (i == 7), (i == 3) || (i == 7));
      end
      @(negedge clk); in_valid = 1'b0; #1;
      chk("b2b_done_valid", 32'(out_valid), 32'd0);

      // backpressure on the first beat
      @(negedge clk); in_valid = 1'b1; in_data = 32'hA5A50F0F; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); in_valid = 1'b0; in_data = 32'h12345678; out_ready = 1'b0; #1;
         beat($sformatf("bp_stall%0d", i), 8'h0F, 1'b0, 1'b0);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); out_ready = 1'b1; #1;
         beat($sformatf("bp%0d", i), exp_bp[i], i == 3, i == 3);
      end
      @(negedge clk); #1;
      chk("bp_done_valid", 32'(out_valid), 32'd0);

      // asynchronous reset in the middle of a word
      @(negedge clk); in_valid = 1'b1; in_data = 32'hDEADBEEF;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         beat($sformatf("mid%0d", i), exp_single[i], 1'b0, 1'b0);
      end
      @(negedge clk); #1;
      chk("mid_pre_rst_data", 32'(out_data), 32'hAD);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_data",  32'(out_data),  32'd0);
      chk("mid_rst_inrdy", 32'(in_ready),  32'd1);
      rst_n = 1'b1;
      @(negedge clk); #1;
      chk("mid_post_valid", 32'(out_valid), 32'd0);
      @(negedge clk); in_valid = 1'b1; in_data = 32'h00000001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); in_valid = 1'b0; #1;
         beat($sformatf("one%0d", i), exp_one[i], i == 3, i == 3);
      end

      // 16-bit beats, MSB first
      @(negedge clk); b_in_valid = 1'b1; b_in_data = 32'hCAFEBABE; b_out_ready = 1'b1; #1;
      chk("msb_idle_inrdy", 32'(b_in_ready), 32'd1);
      @(negedge clk); b_in_valid = 1'b0; #1;
      chk("msb0_valid", 32'(b_out_valid), 32'd1);
      chk("msb0_data",  32'(b_out_data),  32'hCAFE);
      chk("msb0_last",  32'(b_out_last),  32'd0);
      @(negedge clk); #1;
      chk("msb1_data",  32'(b_out_data),  32'hBABE);
      chk("msb1_last",  32'(b_out_last),  32'd1);
      chk("msb1_inrdy", 32'(b_in_ready),  32'd1);
      @(negedge clk); #1;
      chk("msb_done_valid", 32'(b_out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/stream_downsizer.md
Name: stream_downsizer

Overview:
Width-reducing stream adapter placed directly downstream of fifo_top. It consumes full words from the FIFO's out_valid/out_ready/out_data side and emits them as a sequence of narrower beats over a valid/ready handshake. A single holding register and a beat counter give full throughput, with no bubble between consecutive words. The block is used where a narrow fabric link or serial port drains 32-bit FIFO words.

Parameters:
IN_WIDTH, 32, width of the input word; must match the FIFO data width.
OUT_WIDTH, 8, width of each output beat. IN_WIDTH % OUT_WIDTH must be 0, otherwise elaboration fails with $fatal.
MSB_FIRST, 0, beat order. 0 emits the least significant slice first; 1 emits the most significant slice first.
Derived: RATIO = IN_WIDTH/OUT_WIDTH. CNT_W = max(1, $clog2(RATIO)).

Ports:
clk        input   1          clock; all state updates on posedge
rst_n      input   1          asynchronous, active-low reset
in_valid   input   1          upstream word valid (driven by fifo_top out_valid)
in_ready   output  1          block can accept a word (drives fifo_top out_ready)
in_data    input   IN_WIDTH   upstream word
out_valid  output  1          current beat valid
out_ready  input   1          downstream accepts the beat
out_data   output  OUT_WIDTH  current beat
out_last   output  1          high with the final beat of a word

Behaviour:
- State: busy (1b), hold (IN_WIDTH), cnt (CNT_W). Two logical states:
  - IDLE: busy=0.
  - BUSY: busy=1, cnt selects the current slice.
- Reset (async, rst_n=0): busy=0, cnt=0, hold=0, applied immediately and not waiting for a clock edge.
  - Output values in reset: out_valid=0, out_last=0, out_data=0, in_ready=1.
  - Reset mid-word discards the remaining beats. No partial word resumes after reset.
- Fire definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- out_valid = busy.
- out_last = busy & (cnt == RATIO-1).
- out_data:
  - MSB_FIRST=0: hold[cnt*OUT_WIDTH +: OUT_WIDTH].
  - MSB_FIRST=1: hold[(RATIO-1-cnt)*OUT_WIDTH +: OUT_WIDTH].
  - When busy=0, out_data = 0.
- in_ready = !busy | (out_ready & out_last). This is combinational from out_ready, so a new word is accepted in the same cycle the last beat leaves.
- Transitions on posedge:
  - IDLE & in_fire: hold <= in_data, cnt <= 0, busy <= 1.
  - BUSY & out_fire & !out_last: cnt <= cnt+1.
  - BUSY & out_fire & out_last & in_fire: hold <= in_data, cnt <= 0, busy stays 1. This is the back-to-back case with no idle cycle.
  - BUSY & out_fire & out_last & !in_fire: busy <= 0, cnt <= 0.
  - BUSY & !out_ready: all state holds; out_data and out_valid stay stable.
- Latency: a word accepted at edge k shows its first beat with out_valid=1 after edge k. Each word takes exactly RATIO beats.
- Sustained throughput with out_ready=1 and in_valid=1: one beat per cycle, one word per RATIO cycles.
- RATIO=1: the block acts as a one-entry pipeline register. out_last is always 1 while busy, and full throughput holds.
- Handshake rules:
  - out_valid never drops without out_fire, except on reset.
  - in_data is sampled only on in_fire.
- cnt never exceeds RATIO-1. There is no wrap-around beyond the last beat.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, release, check after 1 cycle -> out_valid=0, out_last=0, in_ready=1. Assert rst_n mid-cycle with no clock edge -> out_valid drops to 0 immediately.
- Single word, LSB first (defaults): push 32'hDEADBEEF, out_ready=1 -> beats EF, BE, AD, DE on 4 consecutive cycles; out_last=1 only on DE; then out_valid=0 and in_ready=1.
- Back-to-back words: in_valid held with 32'h11223344 then 32'hCAFEF00D, out_ready=1 -> 8 consecutive beats 44,33,22,11,0D,F0,FE,CA with no gap; in_ready=1 only in the cycle of beats 11 and CA, plus the initial idle cycle.
- Backpressure: push 32'hA5A5_0F0F, out_ready=0 for 5 cycles after the first beat -> out_data=0F and out_valid=1 stable throughout, in_ready=0; release -> remaining beats 0F,A5,A5 in order.
- MSB_FIRST=1, OUT_WIDTH=16: push 32'hCAFEBABE -> beats CAFE then BABE, out_last on BABE.
- Reset mid-word: push 32'hDEADBEEF, accept 2 beats, pulse rst_n low -> out_valid=0 and no further beats; the next push of 32'h00000001 yields 01,00,00,00.
